// File: rtl/mem_write_checker.sv
// In-order store checker: snoops the data-memory write bus and compares stores against a table.
// Verdict, counters and diagnostics are registered, so they update one cycle after the sampled store.
module mem_write_checker #(
   parameter int                  ADDR_W      = 32,
   parameter int                  DATA_W      = 32,
   parameter int                  N_EXP       = 4,
   parameter int                  IGNORE_EN   = 1,
   parameter logic [ADDR_W-1:0]   IGNORE_ADDR = ADDR_W'(96),
   parameter int                  STRICT      = 1,
   parameter int                  TIMEOUT     = 1000,
   localparam int                 IDX_W       = (N_EXP > 1) ? $clog2(N_EXP) : 1,
   localparam int                 CNT_W       = $clog2(N_EXP + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              exp_we,
   input  logic [IDX_W-1:0]  exp_idx,
   input  logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [CNT_W-1:0]  exp_count,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] data_adr,
   input  logic [DATA_W-1:0] write_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [2:0]        fail_code,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [CNT_W-1:0]  match_cnt,
   output logic [15:0]       write_cnt,
   output logic [31:0]       cycle_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

   localparam logic [2:0] FC_NONE    = 3'd0;
   localparam logic [2:0] FC_DATA    = 3'd1;
   localparam logic [2:0] FC_ADDR    = 3'd2;
   localparam logic [2:0] FC_TIMEOUT = 3'd3;
   localparam logic [2:0] FC_CONFIG  = 3'd4;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   match_q, match_d;
   logic [15:0]        wcnt_q, wcnt_d;
   logic [31:0]        ccnt_q, ccnt_d;
   logic [2:0]         code_q, code_d;
   logic [ADDR_W-1:0]  faddr_q, faddr_d;

   logic [ADDR_W-1:0]  tbl_addr_q [N_EXP];
   logic [DATA_W-1:0]  tbl_data_q [N_EXP];

   logic [ADDR_W-1:0]  cur_addr;
   logic [DATA_W-1:0]  cur_data;
   logic               addr_hit, data_hit, last_entry, cfg_bad, tbl_we;

   assign cur_addr   = tbl_addr_q[ptr_q];
   assign cur_data   = tbl_data_q[ptr_q];
   assign addr_hit   = (data_adr == cur_addr);
   assign data_hit   = (write_data == cur_data);
   assign last_entry = (CNT_W'(ptr_q) == (count_q - CNT_W'(1)));
   assign cfg_bad    = (exp_count == '0) || (exp_count > CNT_W'(N_EXP));
   assign tbl_we     = (state_q == IDLE) && exp_we && (int'(exp_idx) < N_EXP);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      count_d = count_q;
      match_d = match_q;
      wcnt_d  = wcnt_q;
      ccnt_d  = ccnt_q;
      code_d  = code_q;
      faddr_d = faddr_q;

      case (state_q)
         RUN: begin
            if (mem_write) begin
               if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
               if (addr_hit && data_hit) begin
                  match_d = match_q + CNT_W'(1);
                  if (last_entry) state_d = PASS;
                  else            ptr_d   = ptr_q + IDX_W'(1);
               end else if ((IGNORE_EN != 0) && (data_adr == IGNORE_ADDR)) begin
                  state_d = RUN;
               end else if (addr_hit) begin
                  state_d = FAIL;
                  code_d  = FC_DATA;
                  faddr_d = data_adr;
               end else if (STRICT != 0) begin
                  state_d = FAIL;
                  code_d  = FC_ADDR;
                  faddr_d = data_adr;
               end
            end
            // A completing match or a store failure on the deadline cycle outranks the timeout.
            if ((state_d == RUN) && (ccnt_q == 32'(TIMEOUT - 1))) begin
               state_d = FAIL;
               code_d  = FC_TIMEOUT;
               faddr_d = '0;
            end
            if (state_d == RUN) ccnt_d = ccnt_q + 32'd1;
         end
         default: begin
            if (start) begin
               ptr_d   = '0;
               match_d = '0;
               wcnt_d  = '0;
               ccnt_d  = '0;
               faddr_d = '0;
               count_d = exp_count;
               if (cfg_bad) begin
                  state_d = FAIL;
                  code_d  = FC_CONFIG;
               end else begin
                  state_d = RUN;
                  code_d  = FC_NONE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         count_q <= '0;
         match_q <= '0;
         wcnt_q  <= '0;
         ccnt_q  <= '0;
         code_q  <= FC_NONE;
         faddr_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         count_q <= count_d;
         match_q <= match_d;
         wcnt_q  <= wcnt_d;
         ccnt_q  <= ccnt_d;
         code_q  <= code_d;
         faddr_q <= faddr_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_EXP; i++) begin
            tbl_addr_q[i] <= '0;
            tbl_data_q[i] <= '0;
         end
      end else if (tbl_we) begin
         tbl_addr_q[exp_idx] <= exp_addr;
         tbl_data_q[exp_idx] <= exp_data;
      end
   end

   assign busy      = (state_q == RUN);
   assign pass      = (state_q == PASS);
   assign fail      = (state_q == FAIL);
   assign done      = pass | fail;
   assign fail_code = code_q;
   assign fail_addr = faddr_q;
   assign match_cnt = match_q;
   assign write_cnt = wcnt_q;
   assign cycle_cnt = ccnt_q;

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable, parametrised successor to the bench-level store checker used on the pipelined core.
- Snoops the core's data-memory write bus (mem_write, data_adr, write_data) and compares stores in order against a programmable table of up to N_EXP expected (address, data) pairs.
- Tolerates writes to one designated scratch address and detects data mismatch, unexpected stores and timeout.
- Reports sticky pass/fail plus diagnostics, for use in simulation and in FPGA self-test wrappers around top.

Parameters:
- ADDR_W, 32, width of data_adr/exp_addr
- DATA_W, 32, width of write_data/exp_data
- N_EXP, 4, depth of the expected-store table (>=1)
- IGNORE_EN, 1, 1 = writes to IGNORE_ADDR are tolerated
- IGNORE_ADDR, 96, scratch address tolerated when IGNORE_EN=1
- STRICT, 1, 1 = any non-ignored, non-matching store fails; 0 = such stores are skipped
- TIMEOUT, 1000, RUN cycles allowed before timeout fail (>=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  arm/re-arm checker (pulse)
- exp_we  in  1  table write strobe
- exp_idx  in  clog2(N_EXP) (min 1)  table write index
- exp_addr  in  ADDR_W  expected store address
- exp_data  in  DATA_W  expected store data
- exp_count  in  clog2(N_EXP+1)  number of valid table entries, sampled on start
- mem_write  in  1  core store strobe
- data_adr  in  ADDR_W  core store address
- write_data  in  DATA_W  core store data
- busy  out  1  state==RUN
- done  out  1  state==PASS or FAIL
- pass  out  1  state==PASS
- fail  out  1  state==FAIL
- fail_code  out  3  0 none, 1 data mismatch, 2 unexpected address, 3 timeout, 4 config error
- fail_addr  out  ADDR_W  data_adr of the failing store (0 for codes 3/4)
- match_cnt  out  clog2(N_EXP+1)  entries matched so far
- write_cnt  out  16  stores seen in RUN, ignored ones included, saturating at 0xFFFF
- cycle_cnt  out  32  cycles spent in RUN

Behaviour:
- States: IDLE, RUN, PASS, FAIL.
- reset low (async): state=IDLE; all outputs 0; table entries cleared to 0; ptr=0.
- IDLE:
  - exp_we writes entry[exp_idx]; exp_idx >= N_EXP is ignored.
  - start with 1 <= exp_count <= N_EXP: go to RUN; clear ptr, match_cnt, write_cnt, cycle_cnt, fail_code, fail_addr.
  - start with exp_count == 0 or exp_count > N_EXP: go to FAIL, fail_code=4.
- RUN: cycle_cnt increments every cycle. On a cycle with mem_write=1:
  - write_cnt increments.
  - data_adr==entry[ptr].addr and write_data==entry[ptr].data: ptr++, match_cnt++. If this was the last entry (ptr==exp_count-1), go to PASS.
  - Else, if IGNORE_EN and data_adr==IGNORE_ADDR: no effect beyond write_cnt.
  - Else, address matches but data differs: FAIL, code 1, fail_addr latched.
  - Else, STRICT=1: FAIL, code 2, fail_addr latched. STRICT=0: store skipped.
  - Table match takes priority over the ignore check when IGNORE_ADDR is itself an expected address.
- Timeout: in RUN, if cycle_cnt==TIMEOUT-1 and no completing match that cycle, go to FAIL, code 3. A final match on the same edge wins (PASS).
- Latency: status reflects a store one cycle after the rising edge that samples it. Flags are registered; no combinational path from bus inputs to outputs.
- PASS/FAIL are sticky, and all counters freeze.
  - start from PASS or FAIL re-arms directly into RUN (same rules as IDLE, including the config check).
  - start while in RUN is ignored.
- exp_we outside IDLE is ignored; table contents persist across runs.
- pass and fail are never both 1. done = pass | fail. busy and done are mutually exclusive.

Test Plan:
- Defaults, entry0=(100,7), exp_count=1: start; stores (96,3) then (100,7) -> pass=1 one cycle after the second store; write_cnt=2, match_cnt=1, fail_code=0.
- Defaults, entry0=(100,7): store (100,8) -> fail=1, fail_code=1, fail_addr=100, match_cnt=0.
- N_EXP=4, entries (4,1),(8,2),(12,3),(16,4): stores in order with (96,x) interleaved -> PASS after store 16, match_cnt=4. Swap 8/12 with STRICT=1 -> FAIL code 2, fail_addr=12. Same swap with STRICT=0 -> no fail, times out (code 3).
- TIMEOUT=50, no stores -> fail_code=3 with cycle_cnt=49. Final matching store on cycle 49 -> pass=1.
- exp_count=0 on start -> fail_code=4 next cycle. Then start with exp_count=1 -> busy=1, fail=0, counters 0.
- reset driven low mid-RUN between clock edges -> all outputs 0 immediately; table cleared; start required to resume.
